// File: rtl/serial_to_parallel.sv
// rtl/serial_to_parallel.sv - byte-to-word assembler on the UART receive path
//
// Packs received bytes MSB-first into an N-bit word and presents it with a
// valid/ready handshake. One completed word can wait in the shift register
// (FULL) while the output register still holds the previous word.
//
// Optional feature: define SERIAL_TO_PARALLEL_TIMEOUT_EN to discard a partial
// word after TIMEOUT idle cycles. Without it, the timeout output is tied to 0.
//
// Ports:
//   clk       in   clock, rising edge
//   rst_n     in   asynchronous active-low reset
//   rx_valid  in   one-cycle byte strobe from the UART receiver
//   rx_byte   in   received byte
//   tx_ready  in   downstream accepts tx_bytes this cycle
//   tx_bytes  out  assembled word, stable while tx_valid is high
//   tx_valid  out  tx_bytes holds an unconsumed word
//   overrun   out  sticky: a byte was dropped with both buffers full
//   timeout   out  one-cycle pulse when a partial word is discarded

module serial_to_parallel #(
    parameter int N       = 32,
    parameter int CNT_W   = 3,
    parameter int TIMEOUT = 1000000
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         rx_valid,
    input  logic [7:0]   rx_byte,
    input  logic         tx_ready,
    output logic [N-1:0] tx_bytes,
    output logic         tx_valid,
    output logic         overrun,
    output logic         timeout
);

    localparam logic [CNT_W-1:0] WORD_BYTES = CNT_W'(N / 8);
    localparam logic [CNT_W-1:0] LAST_IDX   = CNT_W'(N / 8 - 1);

    logic [N-1:0]     sr_q, sr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [N-1:0]     tx_bytes_q, tx_bytes_d;
    logic             tx_valid_q, tx_valid_d;
    logic             overrun_q, overrun_d;

    logic [N-1:0] sr_shifted;
    logic         slot_free;
    logic         is_full;

    assign sr_shifted = {sr_q[N-9:0], rx_byte};
    assign slot_free  = !tx_valid_q || tx_ready;
    assign is_full    = (cnt_q == WORD_BYTES);

`ifdef SERIAL_TO_PARALLEL_TIMEOUT_EN
    localparam int IDLE_W = $clog2(TIMEOUT + 1);
    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT - 1);

    logic [IDLE_W-1:0] idle_q, idle_d;
    logic              timeout_q, timeout_d;
`endif

    always_comb begin
        sr_d       = sr_q;
        cnt_d      = cnt_q;
        tx_bytes_d = tx_bytes_q;
        tx_valid_d = tx_valid_q;
        overrun_d  = overrun_q;
`ifdef SERIAL_TO_PARALLEL_TIMEOUT_EN
        idle_d     = '0;
        timeout_d  = 1'b0;
`endif

        // Consumption; any load below overrides this and keeps valid high.
        if (tx_valid_q && tx_ready) begin
            tx_valid_d = 1'b0;
        end

        if (is_full) begin
            if (slot_free) begin
                tx_bytes_d = sr_q;
                tx_valid_d = 1'b1;
                if (rx_valid) begin
                    // Held word moves out while this byte starts the next one.
                    sr_d  = sr_shifted;
                    cnt_d = CNT_W'(1);
                end else begin
                    cnt_d = '0;
                end
            end else if (rx_valid) begin
                overrun_d = 1'b1;
            end
        end else if (rx_valid) begin
            sr_d = sr_shifted;
            if (cnt_q == LAST_IDX) begin
                if (slot_free) begin
                    tx_bytes_d = sr_shifted;
                    tx_valid_d = 1'b1;
                    cnt_d      = '0;
                end else begin
                    cnt_d = WORD_BYTES;
                end
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
`ifdef SERIAL_TO_PARALLEL_TIMEOUT_EN
        else if (cnt_q != '0) begin
            // PARTIAL and idle: an arriving byte above always wins over expiry.
            if (idle_q == IDLE_LAST) begin
                cnt_d     = '0;
                timeout_d = 1'b1;
            end else begin
                idle_d = idle_q + IDLE_W'(1);
            end
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr_q       <= '0;
            cnt_q      <= '0;
            tx_bytes_q <= '0;
            tx_valid_q <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            sr_q       <= sr_d;
            cnt_q      <= cnt_d;
            tx_bytes_q <= tx_bytes_d;
            tx_valid_q <= tx_valid_d;
            overrun_q  <= overrun_d;
        end
    end

`ifdef SERIAL_TO_PARALLEL_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idle_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            idle_q    <= idle_d;
            timeout_q <= timeout_d;
        end
    end

    assign timeout = timeout_q;
`else
    assign timeout = 1'b0;
`endif

    assign tx_bytes = tx_bytes_q;
    assign tx_valid = tx_valid_q;
    assign overrun  = overrun_q;

endmodule
